timer_ctrl: RTL and testbench
=============================

// Module: timer_ctrl
// PURPOSE
//   Sequencing controller that sits directly upstream of the team's generic up-counter stage.
//   Drives the counter's enable/load/cnt_in from a programmable prescaler.
//   Detects the counter's overflow and raises an interrupt with an ack handshake.
//   Supports one-shot and periodic (auto-reload) modes.
// PARAMETERS
//   counter_size   8  width of the attached counter and of reload_val / cnt_load_val
//   prescale_size  8  width of prescale_div and the internal prescaler count
// PORTS
//   clk           in   1              single clock; all state on posedge
//   res_n         in   1              reset, asynchronous, active-low
//   start         in   1              pulse; starts a run when idle
//   stop          in   1              pulse; aborts a run, no irq
//   periodic      in   1              mode, latched at start: 1=auto-reload, 0=one-shot
//   reload_val    in   counter_size   counter start value, latched at start
//   prescale_div  in   prescale_size  tick divider, latched at start
//   cnt_overflow  in   1              overflow flag from the counter stage
//   irq_ack       in   1              clears irq and missed
//   cnt_enable    out  1              to counter enable
//   cnt_load      out  1              to counter load
//   cnt_load_val  out  counter_size   to counter cnt_in (latched reload_val)
//   busy          out  1              state != IDLE
//   irq           out  1              sticky expiry flag
//   missed        out  1              expiry occurred while irq already set (sticky)
// BEHAVIOUR
//   Reset (res_n=0, async): state=IDLE, prescaler=0, all outputs and latches 0.
//   FSM states: IDLE, LOAD, RUN, TICK, CHECK. Outputs are Moore-decoded from state.
//   - IDLE:  start=1 & stop=0 -> latch periodic/reload_val/prescale_div, go to LOAD.
//   - LOAD:  cnt_enable=1, cnt_load=1 for exactly 1 cycle; prescaler cleared; -> RUN.
//   - RUN:   prescaler increments each cycle.
//            When prescaler == latched div -> clear it, go to TICK.
//            div=0 gives 1 RUN cycle.
//   - TICK:  cnt_enable=1, cnt_load=0 for 1 cycle; counter increments at end of cycle; -> CHECK.
//   - CHECK: no counter strobes; sample cnt_overflow (valid this cycle).
//            0 -> RUN.
//            1 -> expiry: periodic ? LOAD : IDLE.
//   Tick spacing: div+3 cycles. Ticks to expiry: 2^counter_size - reload_val (reload 0 -> 2^N).
//   irq rises at edge E0 + 1 + (2^N - reload_val)*(div+3), where E0 is the edge sampling start.
//   irq/missed update rules:
//   - expiry & irq=0 -> irq=1.
//   - expiry & irq=1 & !irq_ack -> missed=1.
//   - irq_ack & !expiry -> irq=0, missed=0.
//   - irq_ack & expiry same cycle -> irq=1, missed=0 (new event wins, old one acknowledged).
//   Boundaries:
//   - start while busy: ignored; latched configuration unchanged.
//   - start & stop together in IDLE: stop wins; stay IDLE.
//   - stop in any non-IDLE state: IDLE next cycle; no irq. A TICK/LOAD strobe already
//     asserted in that cycle still takes effect in the counter.
//   - reload_val = all-ones: 1 tick to expiry.
//   - Changing inputs mid-run has no effect until the next start.
//   - Reset mid-run: immediate IDLE, strobes drop asynchronously. The counter stage's own
//     reset is separate; the controller issues no load until the next start.
// STRUCTURE
//   Shared package/include timer_pkg: FSM state encodings (3-bit localparams); TICK_OVERHEAD=2.
//   One sub-module: tick_prescaler (clr, en, div -> wrap pulse), prescale_size wide.
//   FSM, config latches and irq logic live in timer_ctrl.
// TESTING (bench instantiates timer_ctrl driving the counter stage, counter_size=8)
//   1. One-shot, reload=8'hFD, div=0, start at E0
//      -> 3 TICK pulses; irq=1 and busy=0 after E10; cnt_load seen once.
//   2. Periodic, reload=8'hFE, div=1, ack each irq
//      -> first irq after E0+9; cnt_load pulses and irq every 9 cycles; missed=0.
//   3. Periodic, reload=8'hFF, div=0, no ack
//      -> irq=1 after the first expiry, missed=1 after the second; one irq_ack clears both.
//   4. Stop during RUN of a reload=8'h00 run
//      -> busy=0 next cycle, no irq. start pulsed mid-run ignored (cnt_load_val unchanged).
//   5. Assert res_n=0 between edges during TICK
//      -> cnt_enable, busy, irq, missed all 0 without a clock edge.
//   6. irq_ack asserted in the same cycle as a periodic expiry with irq=1
//      -> irq stays 1, missed stays 0.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state encodings and constants for the timer controller
package timer_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_TICK  = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;

    // Cycles per tick beyond the prescaler's RUN cycles (one TICK plus one CHECK)
    localparam int TICK_OVERHEAD = 2;

    typedef enum logic [2:0] {
        IDLE  = ST_IDLE,
        LOAD  = ST_LOAD,
        RUN   = ST_RUN,
        TICK  = ST_TICK,
        CHECK = ST_CHECK
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - free-running divider that pulses wrap when its count reaches div
module tick_prescaler #(
    parameter int prescale_size = 8
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic [prescale_size-1:0] div,
    output logic                     wrap
);

    localparam logic [prescale_size-1:0] ONE = 1;

    logic [prescale_size-1:0] count;

    // wrap is only meaningful while counting, so div=0 yields a wrap on the first enabled cycle
    assign wrap = en && (count == div);

    // Count enabled cycles, restarting from zero on clear or on wrap
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            count <= '0;
        end else if (clr || wrap) begin
            count <= '0;
        end else if (en) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - sequencing controller driving an up-counter stage with irq/ack handshake
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int counter_size  = 8,
    parameter int prescale_size = 8
) (
    input  logic                     clk,
    input  logic                     res_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     periodic,
    input  logic [counter_size-1:0]  reload_val,
    input  logic [prescale_size-1:0] prescale_div,
    input  logic                     cnt_overflow,
    input  logic                     irq_ack,
    output logic                     cnt_enable,
    output logic                     cnt_load,
    output logic [counter_size-1:0]  cnt_load_val,
    output logic                     busy,
    output logic                     irq,
    output logic                     missed
);

    state_t                   state;
    state_t                   state_nxt;
    logic                     periodic_q;
    logic [counter_size-1:0]  reload_q;
    logic [prescale_size-1:0] div_q;
    logic                     wrap;
    logic                     launch;
    logic                     expiry;

    // A run only begins from IDLE; stop takes priority over a simultaneous start
    assign launch = (state == IDLE) && start && !stop;

    // A stop in the CHECK cycle aborts the run and suppresses the expiry
    assign expiry = (state == CHECK) && cnt_overflow && !stop;

    assign busy         = (state != IDLE);
    assign cnt_load_val = reload_q;

    tick_prescaler #(
        .prescale_size(prescale_size)
    ) u_prescaler (
        .clk  (clk),
        .res_n(res_n),
        .clr  (state == LOAD),
        .en   (state == RUN),
        .div  (div_q),
        .wrap (wrap)
    );

    // State register
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and Moore counter strobes
    always_comb begin
        state_nxt  = state;
        cnt_enable = 1'b0;
        cnt_load   = 1'b0;
        case (state)
            IDLE: begin
                if (launch) state_nxt = LOAD;
            end
            LOAD: begin
                cnt_enable = 1'b1;
                cnt_load   = 1'b1;
                state_nxt  = stop ? IDLE : RUN;
            end
            RUN: begin
                if (stop)      state_nxt = IDLE;
                else if (wrap) state_nxt = TICK;
            end
            TICK: begin
                cnt_enable = 1'b1;
                state_nxt  = stop ? IDLE : CHECK;
            end
            CHECK: begin
                if (stop)              state_nxt = IDLE;
                else if (!cnt_overflow) state_nxt = RUN;
                else                   state_nxt = periodic_q ? LOAD : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Configuration is captured only when a run launches, so mid-run input changes are ignored
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            periodic_q <= 1'b0;
            reload_q   <= '0;
            div_q      <= '0;
        end else if (launch) begin
            periodic_q <= periodic;
            reload_q   <= reload_val;
            div_q      <= prescale_div;
        end
    end

    // Sticky irq/missed; a new expiry wins over a same-cycle ack
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            irq    <= 1'b0;
            missed <= 1'b0;
        end else if (expiry) begin
            irq <= 1'b1;
            if (irq_ack)  missed <= 1'b0;
            else if (irq) missed <= 1'b1;
        end else if (irq_ack) begin
            irq    <= 1'b0;
            missed <= 1'b0;
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// tb/tb_timer_ctrl.sv - self-checking bench for timer_ctrl with an attached 8-bit counter stage
module tb_timer_ctrl;
    import timer_pkg::*;

    logic       clk = 1'b0;
    logic       res_n;
    logic       start, stop, periodic, irq_ack;
    logic [7:0] reload_val, prescale_div;
    logic       cnt_overflow;
    logic       cnt_enable, cnt_load, busy, irq, missed;
    logic [7:0] cnt_load_val;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int e0      = 0;
    bit cmp_on  = 1'b0;

    always #5 clk = ~clk;

    timer_ctrl #(.counter_size(8), .prescale_size(8)) dut (
        .clk(clk), .res_n(res_n), .start(start), .stop(stop), .periodic(periodic),
        .reload_val(reload_val), .prescale_div(prescale_div), .cnt_overflow(cnt_overflow),
        .irq_ack(irq_ack), .cnt_enable(cnt_enable), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .busy(busy), .irq(irq), .missed(missed)
    );

    // Counter stage: load, or increment with a carry flag that holds until the next strobe
    logic [7:0] cnt_q;
    logic       ovf_q;
    assign cnt_overflow = ovf_q;
    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            cnt_q <= 8'h00;
            ovf_q <= 1'b0;
        end else if (cnt_enable && cnt_load) begin
            cnt_q <= cnt_load_val;
            ovf_q <= 1'b0;
        end else if (cnt_enable) begin
            {ovf_q, cnt_q} <= {1'b0, cnt_q} + 9'd1;
        end
    end

    // Edge counter: after edge E, cyc holds E's index
    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobe totals
    int n_tick_seen = 0;
    int n_load_seen = 0;
    always @(negedge clk) begin
        if (res_n && cnt_enable && !cnt_load) n_tick_seen <= n_tick_seen + 1;
        if (res_n && cnt_load)                n_load_seen <= n_load_seen + 1;
    end

    // Behavioural model: a run is a cycle index c into a period of
    // 1 load cycle + ticks*(div+1 run cycles + overhead) cycles.
    bit       m_active;
    int       m_c;
    bit       m_per;
    logic [7:0] m_reload, m_div;
    bit       m_irq, m_missed;
    int       m_span, m_period, m_q, m_phase;
    bit       m_exp;

    always_comb begin
        m_span   = int'(m_div) + 1 + TICK_OVERHEAD;
        m_period = 1 + (256 - int'(m_reload)) * m_span;
        m_exp    = m_active && (m_c == m_period - 1);
        m_q      = 0;
        m_phase  = 0;
        if (m_active) begin
            if (m_c == 0) begin
                m_phase = 1;
            end else begin
                m_q = (m_c - 1) % m_span;
                if (m_q <= int'(m_div))          m_phase = 2;
                else if (m_q == int'(m_div) + 1) m_phase = 3;
                else                             m_phase = 4;
            end
        end
    end

    always @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            m_active <= 1'b0; m_c <= 0; m_per <= 1'b0;
            m_reload <= 8'h00; m_div <= 8'h00; m_irq <= 1'b0; m_missed <= 1'b0;
        end else begin
            if (m_active) begin
                if (stop) m_active <= 1'b0;
                else if (m_exp) begin
                    if (m_per) m_c <= 0;
                    else       m_active <= 1'b0;
                end else m_c <= m_c + 1;
            end else if (start && !stop) begin
                m_active <= 1'b1; m_c <= 0; m_per <= periodic;
                m_reload <= reload_val; m_div <= prescale_div;
            end
            if (m_exp && !stop) begin
                m_irq <= 1'b1;
                if (irq_ack)    m_missed <= 1'b0;
                else if (m_irq) m_missed <= 1'b1;
            end else if (irq_ack) begin
                m_irq <= 1'b0; m_missed <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (res_n && cmp_on) begin
            chk("cyc_cnt_enable", int'(cnt_enable), int'(m_phase == 1 || m_phase == 3));
            chk("cyc_cnt_load", int'(cnt_load), int'(m_phase == 1));
            chk("cyc_busy", int'(busy), int'(m_phase != 0));
            chk("cyc_irq", int'(irq), int'(m_irq));
            chk("cyc_missed", int'(missed), int'(m_missed));
            chk("cyc_load_val", int'(cnt_load_val), int'(m_reload));
        end
    end

    task automatic do_start(input logic per, input logic [7:0] rv, input logic [7:0] dv);
        @(negedge clk);
        #1 periodic = per; reload_val = rv; prescale_div = dv; start = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_to(input int n);
        int g = 0;
        while (cyc != n && g < 5000) begin
            @(negedge clk);
            g++;
        end
        chk("wait_to_timeout", int'(g >= 5000), 0);
    endtask

    task automatic stop_pulse();
        @(negedge clk);
        #1 stop = 1'b1;
        @(negedge clk);
        #1 stop = 1'b0;
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        #1 irq_ack = 1'b1;
        @(negedge clk);
        #1 irq_ack = 1'b0;
    endtask

    initial begin
        int t0, l0, g;
        res_n = 1'b0; start = 1'b0; stop = 1'b0; periodic = 1'b0; irq_ack = 1'b0;
        reload_val = 8'h00; prescale_div = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_cnt_enable", int'(cnt_enable), 0);
        chk("rst_cnt_load", int'(cnt_load), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_irq", int'(irq), 0);
        chk("rst_missed", int'(missed), 0);
        chk("rst_load_val", int'(cnt_load_val), 0);
        #1 res_n = 1'b1;
        cmp_on = 1'b1;

        // 1: one-shot FD, div 0 -> irq after E10
        t0 = n_tick_seen; l0 = n_load_seen;
        do_start(1'b0, 8'hFD, 8'h00);
        wait_to(e0 + 9);
        chk("t1_irq_before", int'(irq), 0);
        chk("t1_busy_before", int'(busy), 1);
        wait_to(e0 + 10);
        chk("t1_irq_after", int'(irq), 1);
        chk("t1_busy_after", int'(busy), 0);
        chk("t1_ticks", n_tick_seen - t0, 3);
        chk("t1_loads", n_load_seen - l0, 1);
        ack_pulse();
        chk("t1_irq_acked", int'(irq), 0);

        // 2: periodic FE, div 1, ack each irq -> every 9 cycles
        do_start(1'b1, 8'hFE, 8'h01);
        for (int i = 1; i <= 3; i++) begin
            g = 0;
            while (!irq && g < 200) begin @(negedge clk); g++; end
            chk("t2_irq_edge", cyc, e0 + 9 * i);
            chk("t2_missed", int'(missed), 0);
            #1 irq_ack = 1'b1;
            @(negedge clk);
            #1 irq_ack = 1'b0;
        end
        stop_pulse();

        // 3: periodic FF, div 0, no ack -> irq then missed; one ack clears both
        do_start(1'b1, 8'hFF, 8'h00);
        wait_to(e0 + 4);
        chk("t3_irq_first", int'(irq), 1);
        chk("t3_missed_first", int'(missed), 0);
        wait_to(e0 + 8);
        chk("t3_irq_second", int'(irq), 1);
        chk("t3_missed_second", int'(missed), 1);
        stop_pulse();
        @(negedge clk);
        #1 irq_ack = 1'b1;
        @(negedge clk);
        chk("t3_irq_cleared", int'(irq), 0);
        chk("t3_missed_cleared", int'(missed), 0);
        #1 irq_ack = 1'b0;

        // 4: reload 00, start ignored while busy, stop during RUN
        do_start(1'b0, 8'h00, 8'h03);
        repeat (3) @(negedge clk);
        #1 reload_val = 8'h55; periodic = 1'b1; prescale_div = 8'h09; start = 1'b1;
        @(negedge clk);
        #1 start = 1'b0;
        chk("t4_load_val_kept", int'(cnt_load_val), 8'h00);
        g = 0;
        while (m_phase != 2 && g < 50) begin @(negedge clk); g++; end
        chk("t4_in_run", int'(busy && !cnt_enable), 1);
        #1 stop = 1'b1;
        @(negedge clk);
        chk("t4_busy_after_stop", int'(busy), 0);
        chk("t4_no_irq", int'(irq), 0);
        #1 stop = 1'b0;

        // 6: ack in the same cycle as a periodic expiry with irq already set
        do_start(1'b1, 8'hFF, 8'h00);
        g = 0;
        while (!m_irq && g < 50) begin @(negedge clk); g++; end
        g = 0;
        while (!m_exp && g < 50) begin @(negedge clk); g++; end
        chk("t6_expiry_cycle", cyc, e0 + 7);
        #1 irq_ack = 1'b1;
        @(negedge clk);
        chk("t6_irq_kept", int'(irq), 1);
        chk("t6_missed_zero", int'(missed), 0);
        #1 irq_ack = 1'b0;
        stop_pulse();
        ack_pulse();

        // 5: async reset between edges during TICK
        do_start(1'b1, 8'hFF, 8'h00);
        wait_to(e0 + 8);
        g = 0;
        while (m_phase != 3 && g < 50) begin @(negedge clk); g++; end
        chk("t5_pre_enable", int'(cnt_enable), 1);
        chk("t5_pre_missed", int'(missed), 1);
        #2 res_n = 1'b0;
        #1;
        chk("t5_cnt_enable", int'(cnt_enable), 0);
        chk("t5_busy", int'(busy), 0);
        chk("t5_irq", int'(irq), 0);
        chk("t5_missed", int'(missed), 0);
        chk("t5_cnt_load", int'(cnt_load), 0);
        #1 res_n = 1'b1;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
